// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending-machine controller: item codes, coin
// values, credit ceiling and FSM state encoding.
package vend_ctrl_pkg;

  localparam logic [1:0] ITEM_APPLE  = 2'd0;
  localparam logic [1:0] ITEM_BANANA = 2'd1;
  localparam logic [1:0] ITEM_CARROT = 2'd2;
  localparam logic [1:0] ITEM_DATE   = 2'd3;

  localparam logic [6:0] COIN_NICKEL  = 7'd5;
  localparam logic [6:0] COIN_DIME    = 7'd10;
  localparam logic [6:0] COIN_QUARTER = 7'd25;

  localparam logic [6:0] MAX_CREDIT = 7'd99;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/vend_ctrl_bin2bcd_99.sv
// Combinational binary (0..99) to two-digit BCD converter.
module bin2bcd_99 (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  logic [3:0] tens;
  logic [3:0] units;

  always_comb begin
    tens = 4'd0;
    for (int t = 1; t < 10; t++) begin
      if (bin >= 7'(t * 10)) tens = 4'(t);
    end
    units = 4'(bin - 7'(tens) * 7'd10);
  end

  assign bcd = {tens, units};

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin credit, item vend/error pulses with a
// selection hold-off window, refund, and BCD credit/refund outputs.
module vend_ctrl
  import vend_ctrl_pkg::*;
#(
  parameter int PRICE_A     = 50,
  parameter int PRICE_B     = 35,
  parameter int PRICE_C     = 25,
  parameter int PRICE_D     = 75,
  parameter int HOLD_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic [1:0] sel,
  input  logic       sel_valid,
  input  logic       refund,
  output logic       apple,
  output logic       banana,
  output logic       carrot,
  output logic       date,
  output logic       error,
  output logic       coin_reject,
  output logic [7:0] credit,
  output logic       refund_pulse,
  output logic [7:0] refund_amt
);

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  function automatic logic [6:0] price_of(input logic [1:0] s);
    case (s)
      ITEM_APPLE:  price_of = 7'(PRICE_A);
      ITEM_BANANA: price_of = 7'(PRICE_B);
      ITEM_CARROT: price_of = 7'(PRICE_C);
      ITEM_DATE:   price_of = 7'(PRICE_D);
      default:     price_of = 7'(PRICE_A);
    endcase
  endfunction

  state_t     state_reg, state_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;
  logic [6:0] cr_reg, cr_next;
  logic [7:0] credit_reg, credit_next;
  logic [7:0] refund_amt_reg, refund_amt_next;
  logic [7:0] refund_bcd;
  logic [3:0] item_reg, item_next;
  logic       error_reg, error_next;
  logic       coin_reject_reg, coin_reject_next;
  logic       refund_pulse_reg, refund_pulse_next;

  logic [6:0] cr_after_ref, cr_after_sel, coin_val, price;
  logic [7:0] coin_sum;
  logic       sel_err, overflow, multi_coin;

  bin2bcd_99 u_credit_bcd (.bin(cr_next), .bcd(credit_next));
  bin2bcd_99 u_refund_bcd (.bin(cr_reg),  .bcd(refund_bcd));

  always_comb begin
    state_next        = state_reg;
    hold_cnt_next     = hold_cnt_reg;
    refund_amt_next   = refund_amt_reg;
    refund_pulse_next = 1'b0;
    coin_reject_next  = 1'b0;
    item_next         = 4'b0000;
    sel_err           = 1'b0;
    overflow          = 1'b0;
    price             = price_of(sel);
    cr_after_ref      = cr_reg;

    // Only the highest-value coin is taken; the others go straight back.
    if (quarter)     coin_val = COIN_QUARTER;
    else if (dime)   coin_val = COIN_DIME;
    else if (nickel) coin_val = COIN_NICKEL;
    else             coin_val = 7'd0;
    multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);

    if (refund) begin
      refund_pulse_next = 1'b1;
      refund_amt_next   = refund_bcd;
      cr_after_ref      = 7'd0;
    end

    cr_after_sel = cr_after_ref;
    if (state_reg == ST_HOLD) begin
      hold_cnt_next = hold_cnt_reg - 4'd1;
      if (hold_cnt_reg <= 4'd1) begin
        hold_cnt_next = 4'd0;
        state_next    = ST_IDLE;
      end
    end else if (sel_valid && !refund) begin
      state_next    = ST_HOLD;
      hold_cnt_next = HOLD_INIT;
      if (cr_after_ref >= price) begin
        cr_after_sel = cr_after_ref - price;
        item_next    = 4'b0001 << sel;
      end else begin
        sel_err = 1'b1;
      end
    end

    coin_sum = {1'b0, cr_after_sel} + {1'b0, coin_val};
    cr_next  = cr_after_sel;
    if (coin_sum > {1'b0, MAX_CREDIT}) begin
      overflow         = 1'b1;
      coin_reject_next = 1'b1;
      if (state_reg == ST_IDLE) begin
        state_next    = ST_HOLD;
        hold_cnt_next = HOLD_INIT;
      end
    end else begin
      cr_next = coin_sum[6:0];
    end
    if (multi_coin) coin_reject_next = 1'b1;

    // A successful vend takes priority over the overflow error indication.
    error_next = sel_err | (overflow & ~(|item_next));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      hold_cnt_reg     <= 4'd0;
      cr_reg           <= 7'd0;
      credit_reg       <= 8'h00;
      refund_amt_reg   <= 8'h00;
      item_reg         <= 4'b0000;
      error_reg        <= 1'b0;
      coin_reject_reg  <= 1'b0;
      refund_pulse_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      hold_cnt_reg     <= hold_cnt_next;
      cr_reg           <= cr_next;
      credit_reg       <= credit_next;
      refund_amt_reg   <= refund_amt_next;
      item_reg         <= item_next;
      error_reg        <= error_next;
      coin_reject_reg  <= coin_reject_next;
      refund_pulse_reg <= refund_pulse_next;
    end
  end

  assign apple        = item_reg[0];
  assign banana       = item_reg[1];
  assign carrot       = item_reg[2];
  assign date         = item_reg[3];
  assign error        = error_reg;
  assign coin_reject  = coin_reject_reg;
  assign refund_pulse = refund_pulse_reg;
  assign credit       = credit_reg;
  assign refund_amt   = refund_amt_reg;

endmodule
